// File: rtl/screen_transition_if.sv
// ----------------------------------------------------------------------------
// screen_transition_if
//   Bundles the display-path signals of screen_transition.
//   master : the side that owns the OLED driver / screen generators
//            (drives frame_begin, pixel_index, screen_sel, screen_data).
//   slave  : screen_transition itself
//            (drives x, y, oled_data, active_scr, busy and the debug view).
//   dbg_state / dbg_level expose the transition FSM state and the current
//   brightness level so checkers can observe the fade directly.
//   Handshake semantics: there is no valid/ready pair on this bus. frame_begin
//   is a single-cycle strobe; every other input is level-sensitive and every
//   output is valid in the same cycle as the inputs it depends on.
// ----------------------------------------------------------------------------
interface screen_transition_if #(
    parameter int NUM_SCREENS = 5,
    parameter int LEVEL_W     = 3
);
    logic                      frame_begin;
    logic [12:0]               pixel_index;
    logic [2:0]                screen_sel;
    logic [16*NUM_SCREENS-1:0] screen_data;
    logic [6:0]                x;
    logic [5:0]                y;
    logic [15:0]               oled_data;
    logic [2:0]                active_scr;
    logic                      busy;
    logic [1:0]                dbg_state;
    logic [LEVEL_W:0]          dbg_level;

    modport master (
        output frame_begin, pixel_index, screen_sel, screen_data,
        input  x, y, oled_data, active_scr, busy, dbg_state, dbg_level
    );

    modport slave (
        input  frame_begin, pixel_index, screen_sel, screen_data,
        output x, y, oled_data, active_scr, busy, dbg_state, dbg_level
    );
endinterface

// File: rtl/screen_transition.sv
// ----------------------------------------------------------------------------
// screen_transition
//   Display-path stage between the screen pixel generators and the OLED driver.
//   - Converts pixel_index (96x64, row-major) into x/y for the screen modules.
//   - Forwards the active screen's RGB565 colour, scaled by a brightness level.
//   - On a screen change: fade out to black, swap screens, fade back in. The
//     fade advances one level per FRAMES_PER_STEP frame_begin pulses.
// Ports
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : screen_transition_if.slave
//            in : frame_begin, pixel_index, screen_sel, screen_data
//            out: x, y, oled_data, active_scr, busy, dbg_state, dbg_level
// ----------------------------------------------------------------------------
module screen_transition #(
    parameter int NUM_SCREENS     = 5,
    parameter int LEVEL_W         = 3,
    parameter int FRAMES_PER_STEP = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    screen_transition_if.slave  bus
);

    localparam logic [LEVEL_W:0] FULL  = (LEVEL_W+1)'(1) << LEVEL_W;
    localparam int               CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int               PW    = 6 + LEVEL_W + 1;

    typedef enum logic [1:0] {
        SHOW     = 2'd0,
        FADE_OUT = 2'd1,
        BLACK    = 2'd2,
        FADE_IN  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [LEVEL_W:0] r_level;
    logic [LEVEL_W:0] w_level_next;
    logic [2:0]       r_active;
    logic [2:0]       w_active_next;
    logic [2:0]       r_target;
    logic [2:0]       w_target_next;
    logic [CNT_W-1:0] r_cnt;

    logic             w_busy;
    logic             w_step;
    logic             w_sel_valid;

    // ------------------------------------------------------------------------
    // Coordinates: indices past the last pixel map to the origin.
    // ------------------------------------------------------------------------
    logic [6:0] w_x;
    logic [5:0] w_y;

    always_comb begin
        w_x = '0;
        w_y = '0;
        if (bus.pixel_index <= 13'd6143) begin
            w_x = 7'(bus.pixel_index % 13'd96);
            w_y = 6'(bus.pixel_index / 13'd96);
        end
    end

    // ------------------------------------------------------------------------
    // Source select and brightness scaling.
    // level==FULL reproduces the channel exactly, since (c*FULL)>>LEVEL_W == c.
    // ------------------------------------------------------------------------
    logic [15:0]   w_src;
    logic [PW-1:0] w_r_prod;
    logic [PW-1:0] w_g_prod;
    logic [PW-1:0] w_b_prod;
    logic [15:0]   w_oled;

    always_comb begin
        w_src = '0;
        for (int k = 0; k < NUM_SCREENS; k++) begin
            if (r_active == 3'(k)) begin
                w_src = bus.screen_data[16*k +: 16];
            end
        end
    end

    always_comb begin
        w_r_prod = PW'(w_src[15:11]) * PW'(r_level);
        w_g_prod = PW'(w_src[10:5])  * PW'(r_level);
        w_b_prod = PW'(w_src[4:0])   * PW'(r_level);
        w_oled   = {5'(w_r_prod >> LEVEL_W),
                    6'(w_g_prod >> LEVEL_W),
                    5'(w_b_prod >> LEVEL_W)};
    end

    // ------------------------------------------------------------------------
    // Step tick: fires on the FRAMES_PER_STEP-th frame_begin seen while busy.
    // In SHOW busy is low, so a pulse coinciding with SHOW->FADE_OUT is ignored.
    // ------------------------------------------------------------------------
    assign w_busy      = (r_state != SHOW);
    assign w_step      = w_busy && bus.frame_begin &&
                         (r_cnt == CNT_W'(FRAMES_PER_STEP - 1));
    assign w_sel_valid = ({1'b0, bus.screen_sel} < 4'(NUM_SCREENS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_state_next != r_state) begin
            r_cnt <= '0;
        end else if (w_busy && bus.frame_begin) begin
            if (w_step) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Transition FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= SHOW;
            r_level  <= FULL;
            r_active <= '0;
            r_target <= '0;
        end else begin
            r_state  <= w_state_next;
            r_level  <= w_level_next;
            r_active <= w_active_next;
            r_target <= w_target_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_level_next  = r_level;
        w_active_next = r_active;
        w_target_next = r_target;
        case (r_state)
            SHOW: begin
                w_level_next = FULL;
                if (w_sel_valid && (bus.screen_sel != r_active)) begin
                    w_target_next = bus.screen_sel;
                    w_state_next  = FADE_OUT;
                end
            end
            FADE_OUT: begin
                // The destination may still change while fading out; selecting
                // the current screen again just re-shows it after the fade.
                if (w_sel_valid) begin
                    w_target_next = bus.screen_sel;
                end
                if (w_step) begin
                    w_level_next = r_level - (LEVEL_W+1)'(1);
                    if (r_level == (LEVEL_W+1)'(1)) begin
                        w_state_next = BLACK;
                    end
                end
            end
            BLACK: begin
                if (w_step) begin
                    w_active_next = r_target;
                    w_level_next  = (LEVEL_W+1)'(1);
                    w_state_next  = FADE_IN;
                end
            end
            FADE_IN: begin
                if (w_step) begin
                    w_level_next = r_level + (LEVEL_W+1)'(1);
                    if (r_level == FULL - (LEVEL_W+1)'(1)) begin
                        w_state_next = SHOW;
                    end
                end
            end
            default: begin
                w_state_next = SHOW;
                w_level_next = FULL;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.x          = w_x;
    assign bus.y          = w_y;
    assign bus.oled_data  = w_oled;
    assign bus.active_scr = r_active;
    assign bus.busy       = w_busy;
    assign bus.dbg_state  = r_state;
    assign bus.dbg_level  = r_level;

endmodule

// File: tb/tb_screen_transition.sv
// ----------------------------------------------------------------------------
// tb_screen_transition
//   Self-checking bench for screen_transition (defaults: 5 screens, 8 levels,
//   2 frames per step). Expected values come from the screen schedule
//   (16 steps: 8 down, 1 black, 7 up) and a per-channel scaling reference.
// ----------------------------------------------------------------------------
module tb_screen_transition;

    localparam int NS = 5;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    screen_transition_if #(.NUM_SCREENS(NS), .LEVEL_W(3)) bus();

    screen_transition #(
        .NUM_SCREENS     (NS),
        .LEVEL_W         (3),
        .FRAMES_PER_STEP (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] slice [NS];

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic sb_check(input string tag, input logic [31:0] got);
        logic [31:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        check_val(tag, got, e);
    endtask

    // ---------------- reference ----------------
    function automatic logic [15:0] scale(input logic [15:0] c, input int lvl);
        int r, g, b;
        r = (int'(c[15:11]) * lvl) / 8;
        g = (int'(c[10:5])  * lvl) / 8;
        b = (int'(c[4:0])   * lvl) / 8;
        return {5'(r), 6'(g), 5'(b)};
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_slices();
        for (int k = 0; k < NS; k++) begin
            bus.screen_data[16*k +: 16] = slice[k];
        end
    endtask

    // Idle gap, then a one-cycle frame_begin; returns just after its edge.
    task automatic frame();
        repeat ($urandom_range(1, 3)) tick();
        bus.frame_begin = 1'b1;
        tick();
        bus.frame_begin = 1'b0;
    endtask

    task automatic step();
        repeat (2) frame();
    endtask

    // Request first_s (optionally with a frame_begin on the request edge),
    // then walk n_steps steps, checking level/screen/busy after each one.
    // After step chg_after the request switches to final_s.
    task automatic run_transition(input int old_s, input int first_s, input int final_s,
                                  input int chg_after, input int n_steps, input bit kick);
        int tgt;
        int lvl;
        int act;
        bus.screen_sel  = 3'(first_s);
        bus.frame_begin = kick;
        tick();
        bus.frame_begin = 1'b0;
        sb_push(32'd1);
        sb_check("start_busy", {31'd0, bus.busy});
        tgt = first_s;
        for (int s = 1; s <= n_steps; s++) begin
            step();
            if (s <= 8) begin
                lvl = 8 - s;
                act = old_s;
            end else begin
                lvl = s - 8;
                act = tgt;
            end
            sb_push({16'd0, scale(slice[act], lvl)});
            sb_check($sformatf("oled_s%0d", s), {16'd0, bus.oled_data});
            sb_push(32'(act));
            sb_check($sformatf("active_s%0d", s), {29'd0, bus.active_scr});
            sb_push((s < 16) ? 32'd1 : 32'd0);
            sb_check($sformatf("busy_s%0d", s), {31'd0, bus.busy});
            if (s == chg_after) begin
                bus.screen_sel = 3'(final_s);
                if (s < 8) tgt = final_s;
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int pix;
        slice[0] = 16'hF81F;
        slice[1] = 16'hF800;
        slice[2] = 16'h07E0;
        slice[3] = 16'h001F;
        slice[4] = 16'hA5A5;
        rst_n           = 1'b0;
        bus.frame_begin = 1'b0;
        bus.screen_sel  = 3'd0;
        bus.pixel_index = 13'd200;
        load_slices();
        repeat (2) tick();

        // Reset state and datapath during reset
        sb_push(32'd8);      sb_check("rst_x",      {25'd0, bus.x});
        sb_push(32'd2);      sb_check("rst_y",      {26'd0, bus.y});
        sb_push(32'hF81F);   sb_check("rst_oled",   {16'd0, bus.oled_data});
        sb_push(32'd0);      sb_check("rst_busy",   {31'd0, bus.busy});
        sb_push(32'd0);      sb_check("rst_active", {29'd0, bus.active_scr});
        rst_n = 1'b1;
        tick();

        // Random coordinates
        for (int i = 0; i < 6; i++) begin
            pix = $urandom_range(0, 6143);
            bus.pixel_index = 13'(pix);
            #1;
            sb_push(32'(pix % 96)); sb_check("rand_x", {25'd0, bus.x});
            sb_push(32'(pix / 96)); sb_check("rand_y", {26'd0, bus.y});
        end

        // Plain transition 0 -> 2 from white; a frame on the request edge is ignored
        slice[0] = 16'hFFFF;
        load_slices();
        #1;
        run_transition(0, 2, 2, 0, 16, 1'b1);
        tick();
        sb_push(32'd0); sb_check("hold_busy", {31'd0, bus.busy});

        // 2 -> 1, retargeted to 3 during fade-out
        run_transition(2, 1, 3, 3, 16, 1'b1);

        // 3 -> 2, request 4 during fade-in: 2 completes, then 4 starts next cycle
        run_transition(3, 2, 4, 11, 16, 1'b1);
        run_transition(2, 4, 4, 0, 16, 1'b0);

        // Out-of-range request is ignored
        bus.screen_sel = 3'd7;
        repeat (3) frame();
        sb_push(32'd0);            sb_check("oor_busy",   {31'd0, bus.busy});
        sb_push(32'd4);            sb_check("oor_active", {29'd0, bus.active_scr});
        sb_push({16'd0, slice[4]}); sb_check("oor_oled",  {16'd0, bus.oled_data});

        // Reset in the middle of fade-out (level 3)
        run_transition(4, 1, 1, 0, 5, 1'b1);
        bus.pixel_index = 13'd6143;
        rst_n = 1'b0;
        #1;
        sb_push(32'd0);             sb_check("abort_active", {29'd0, bus.active_scr});
        sb_push(32'd0);             sb_check("abort_busy",   {31'd0, bus.busy});
        sb_push(32'd8);             sb_check("abort_level",  {28'd0, bus.dbg_level});
        sb_push({16'd0, slice[0]}); sb_check("abort_oled",   {16'd0, bus.oled_data});
        sb_push(32'd95);            sb_check("last_x",       {25'd0, bus.x});
        sb_push(32'd63);            sb_check("last_y",       {26'd0, bus.y});
        bus.pixel_index = 13'd6144;
        #1;
        sb_push(32'd0); sb_check("oob_x", {25'd0, bus.x});
        sb_push(32'd0); sb_check("oob_y", {26'd0, bus.y});
        bus.pixel_index = 13'd96;
        #1;
        sb_push(32'd0); sb_check("row1_x", {25'd0, bus.x});
        sb_push(32'd1); sb_check("row1_y", {26'd0, bus.y});
        bus.screen_sel = 3'd0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        sb_push(32'd0); sb_check("post_rst_busy", {31'd0, bus.busy});

        check_val("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
